read_arbiter: RTL and testbench

//  Output-side counterpart of the SRAM write arbiter. Picks one of num_of_ports output ports that has a

---
 rtl/read_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_read_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_arbiter.sv
// rtl/read_arbiter.sv - output-side SRAM read arbiter with SP/WRR selection and framed per-port streaming
// Purpose: picks one output port with a pending packet descriptor (strict priority or
//   weighted round robin), reads the packet word by word from shared SRAM and streams it
//   to that port with one-hot vld/sop/eop framing and per-port backpressure.
// Ports:
//   clk, rst (sync, active-low)      clock / reset
//   sp0_wrr1                         0 = strict priority, 1 = weighted round robin
//   req, req_priority/addr/len       per-port packed packet descriptors
//   ready                            per-port sink ready
//   grant                            one-hot 1-cycle pulse, port pops its descriptor
//   sram_rd_en/addr, sram_rd_data    SRAM read port (data one cycle after strobe)
//   data_out, vld, sop, eop          shared output bus with one-hot framing
//   busy                             FSM not in IDLE
//   pkt_cnt, word_cnt                only when READ_ARB_STATS_EN is defined
module read_arbiter #(
   parameter int num_of_ports       = 16,
   parameter int arbiter_data_width = 256,
   parameter int priority_width     = 3,
   parameter int addr_width         = 14,
   parameter int len_width          = 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   sp0_wrr1,
   input  logic [num_of_ports-1:0]                req,
   input  logic [num_of_ports*priority_width-1:0] req_priority,
   input  logic [num_of_ports*addr_width-1:0]     req_addr,
   input  logic [num_of_ports*len_width-1:0]      req_len,
   input  logic [num_of_ports-1:0]                ready,
   output logic [num_of_ports-1:0]                grant,
   output logic                                   sram_rd_en,
   output logic [addr_width-1:0]                  sram_rd_addr,
   input  logic [arbiter_data_width-1:0]          sram_rd_data,
   output logic [arbiter_data_width-1:0]          data_out,
   output logic [num_of_ports-1:0]                vld,
   output logic [num_of_ports-1:0]                sop,
   output logic [num_of_ports-1:0]                eop,
   output logic                                   busy
`ifdef READ_ARB_STATS_EN
   ,
   output logic [31:0]                            pkt_cnt,
   output logic [31:0]                            word_cnt
`endif
);

   localparam int SW   = (num_of_ports > 1) ? $clog2(num_of_ports) : 1;
   localparam int CW   = priority_width + 1;
   localparam int CNTW = len_width + 1;

   typedef enum logic [1:0] {IDLE, ARB, READ, DRAIN} state_t;

   state_t                 state;
   logic [SW-1:0]          sel_r;
   logic [addr_width-1:0]  addr_r;
   logic [CNTW-1:0]        cnt_r;
   logic                   first_r;
   logic [SW-1:0]          ptr_r;
   logic [CW-1:0]          credit [num_of_ports];

   logic [SW-1:0]          sp_sel, wrr_sel, arb_sel, next_ptr, widx;
   logic                   sp_found, wrr_found, reload;
   logic [priority_width-1:0] best_prio;
   logic [CW-1:0]          eff_credit [num_of_ports];
   logic [addr_width-1:0]  sel_addr;
   logic [len_width-1:0]   sel_len;
   logic [num_of_ports-1:0] arb_onehot, sel_onehot;
   int                     wj;

   // Strict priority: strictly-greater compare keeps the lowest index on ties.
   always_comb begin
      sp_sel    = '0;
      sp_found  = 1'b0;
      best_prio = '0;
      for (int i = 0; i < num_of_ports; i++) begin
         if (req[i] && (!sp_found ||
             req_priority[i*priority_width +: priority_width] > best_prio)) begin
            sp_found  = 1'b1;
            sp_sel    = SW'(i);
            best_prio = req_priority[i*priority_width +: priority_width];
         end
      end
   end

   // WRR credits reload for every port when no requesting port has credit left;
   // the reloaded values are used by the search in the same ARB cycle.
   always_comb begin
      reload = 1'b1;
      for (int i = 0; i < num_of_ports; i++) begin
         if (req[i] && credit[i] != '0) reload = 1'b0;
      end
      for (int i = 0; i < num_of_ports; i++) begin
         eff_credit[i] = reload ?
            CW'(req_priority[i*priority_width +: priority_width]) + CW'(1) : credit[i];
      end
   end

   // Circular search starting at the pointer.
   always_comb begin
      wrr_sel   = ptr_r;
      wrr_found = 1'b0;
      wj        = 0;
      widx      = '0;
      for (int k = 0; k < num_of_ports; k++) begin
         wj = int'(ptr_r) + k;
         if (wj >= num_of_ports) wj = wj - num_of_ports;
         widx = SW'(wj);
         if (!wrr_found && req[widx] && eff_credit[widx] != '0) begin
            wrr_found = 1'b1;
            wrr_sel   = widx;
         end
      end
   end

   assign arb_sel  = sp0_wrr1 ? wrr_sel : sp_sel;
   assign next_ptr = (wrr_sel == SW'(num_of_ports - 1)) ? '0 : wrr_sel + 1'b1;

   always_comb begin
      sel_addr   = '0;
      sel_len    = '0;
      arb_onehot = '0;
      sel_onehot = '0;
      for (int i = 0; i < num_of_ports; i++) begin
         if (arb_sel == SW'(i)) begin
            sel_addr      = req_addr[i*addr_width +: addr_width];
            sel_len       = req_len[i*len_width +: len_width];
            arb_onehot[i] = 1'b1;
         end
         if (sel_r == SW'(i)) sel_onehot[i] = 1'b1;
      end
   end

   // The read strobe follows the selected sink's ready in the same cycle.
   assign sram_rd_en   = (state == READ) && ready[sel_r];
   assign sram_rd_addr = addr_r;
   assign busy         = (state != IDLE);
   // SRAM data arrives in the cycle vld is high; keep the bus at zero otherwise.
   assign data_out     = (|vld) ? sram_rd_data : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         grant   <= '0;
         vld     <= '0;
         sop     <= '0;
         eop     <= '0;
         sel_r   <= '0;
         addr_r  <= '0;
         cnt_r   <= '0;
         first_r <= 1'b0;
         ptr_r   <= '0;
         for (int i = 0; i < num_of_ports; i++) credit[i] <= '0;
      end else begin
         grant <= '0;
         vld   <= sram_rd_en ? sel_onehot : '0;
         sop   <= (sram_rd_en && first_r) ? sel_onehot : '0;
         eop   <= (sram_rd_en && cnt_r == CNTW'(1)) ? sel_onehot : '0;
         case (state)
            IDLE: if (|req) state <= ARB;
            ARB: begin
               if (|req) begin
                  grant   <= arb_onehot;
                  sel_r   <= arb_sel;
                  addr_r  <= sel_addr;
                  cnt_r   <= CNTW'(sel_len) + CNTW'(1);
                  first_r <= 1'b1;
                  state   <= READ;
                  if (sp0_wrr1 && wrr_found) begin
                     for (int i = 0; i < num_of_ports; i++) credit[i] <= eff_credit[i];
                     credit[wrr_sel] <= eff_credit[wrr_sel] - CW'(1);
                     ptr_r <= (eff_credit[wrr_sel] == CW'(1)) ? next_ptr : wrr_sel;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            READ: begin
               if (ready[sel_r]) begin
                  addr_r  <= addr_r + 1'b1;
                  cnt_r   <= cnt_r - CNTW'(1);
                  first_r <= 1'b0;
                  if (cnt_r == CNTW'(1)) state <= DRAIN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef READ_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         pkt_cnt  <= '0;
         word_cnt <= '0;
      end else begin
         if (|eop) pkt_cnt  <= pkt_cnt + 32'd1;
         if (|vld) word_cnt <= word_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_read_arbiter.sv
// tb/tb_read_arbiter.sv - scoreboard bench for read_arbiter
module tb_read_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         sp0_wrr1;
   logic [15:0]  req;
   logic [47:0]  req_priority;
   logic [223:0] req_addr;
   logic [127:0] req_len;
   logic [15:0]  ready;
   logic [15:0]  grant;
   logic         sram_rd_en;
   logic [13:0]  sram_rd_addr;
   logic [255:0] sram_rd_data = '0;
   logic [255:0] data_out;
   logic [15:0]  vld, sop, eop;
   logic         busy;
`ifdef READ_ARB_STATS_EN
   logic [31:0]  pkt_cnt, word_cnt;
`endif

   read_arbiter dut (
      .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .req(req),
      .req_priority(req_priority), .req_addr(req_addr), .req_len(req_len),
      .ready(ready), .grant(grant), .sram_rd_en(sram_rd_en),
      .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
      .data_out(data_out), .vld(vld), .sop(sop), .eop(eop), .busy(busy)
`ifdef READ_ARB_STATS_EN
      , .pkt_cnt(pkt_cnt), .word_cnt(word_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int           port;
      logic [255:0] data;
      logic         sop;
      logic         eop;
   } beat_t;

   beat_t sb [$];
   int    gq [$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    beats_seen = 0;

   logic [2:0]  d_prio [16];
   logic [13:0] d_addr [16];
   logic [7:0]  d_len  [16];
   int          d_cnt  [16];

   function automatic logic [255:0] mem_word(input logic [13:0] a);
      return {8{18'h2A5A5, a}};
   endfunction

   // SRAM: data valid the cycle after the strobe
   always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem_word(sram_rd_addr);

   task automatic drive_req();
      for (int i = 0; i < 16; i++) begin
         req[i]              = (d_cnt[i] != 0);
         req_priority[i*3 +: 3]   = d_prio[i];
         req_addr[i*14 +: 14]     = d_addr[i];
         req_len[i*8 +: 8]        = d_len[i];
      end
   endtask

   task automatic load(input int p, input logic [2:0] pr, input logic [13:0] a,
                       input logic [7:0] l, input int cnt);
      d_prio[p] = pr; d_addr[p] = a; d_len[p] = l; d_cnt[p] = cnt;
      drive_req();
   endtask

   task automatic push_pkt(input int p, input logic [13:0] a, input int l);
      beat_t b;
      logic [13:0] wa;
      gq.push_back(p);
      for (int k = 0; k <= l; k++) begin
         wa = a + 14'(k);
         b.port = p; b.data = mem_word(wa); b.sop = (k == 0); b.eop = (k == l);
         sb.push_back(b);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Monitor: grants and beats popped from the scoreboard as they appear.
   always @(negedge clk) begin
      beat_t       mb;
      logic [15:0] ev;
      int          gp;
      if (grant !== 16'h0) begin
         n_tests++;
         if (gq.size() == 0) begin
            n_fail++;
            $display("FAIL grant_unexpected: got %h, expected none", grant);
         end else begin
            gp = gq.pop_front();
            ev = '0; ev[gp] = 1'b1;
            if (grant !== ev) begin
               n_fail++;
               $display("FAIL grant_order: got %h, expected %h", grant, ev);
            end
         end
         for (int i = 0; i < 16; i++) if (grant[i] && d_cnt[i] > 0) d_cnt[i]--;
         drive_req();
      end
      if (vld !== 16'h0) begin
         n_tests++;
         beats_seen++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got vld=%h data=%h, expected none", vld, data_out);
         end else begin
            mb = sb.pop_front();
            ev = '0; ev[mb.port] = 1'b1;
            if (vld !== ev || sop !== (mb.sop ? ev : 16'h0) ||
                eop !== (mb.eop ? ev : 16'h0) || data_out !== mb.data) begin
               n_fail++;
               $display("FAIL beat: got vld=%h sop=%h eop=%h data=%h, expected vld=%h sop=%h eop=%h data=%h",
                        vld, sop, eop, data_out, ev, mb.sop ? ev : 16'h0, mb.eop ? ev : 16'h0, mb.data);
            end
         end
      end
   end

   task automatic wait_done(input string name, input int budget);
      int c = 0;
      while (!(sb.size() == 0 && gq.size() == 0 && !busy && req == 16'h0) && c < budget) begin
         tick();
         c++;
      end
      n_tests++;
      if (c >= budget) begin
         n_fail++;
         $display("FAIL %s_done: got %0d beats and %0d grants outstanding, expected 0", name, sb.size(), gq.size());
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_tests += 8;
      if (grant !== 16'h0)      begin n_fail++; $display("FAIL %s_grant: got %h, expected 0", name, grant); end
      if (vld !== 16'h0)        begin n_fail++; $display("FAIL %s_vld: got %h, expected 0", name, vld); end
      if (sop !== 16'h0)        begin n_fail++; $display("FAIL %s_sop: got %h, expected 0", name, sop); end
      if (eop !== 16'h0)        begin n_fail++; $display("FAIL %s_eop: got %h, expected 0", name, eop); end
      if (sram_rd_en !== 1'b0)  begin n_fail++; $display("FAIL %s_rd_en: got %b, expected 0", name, sram_rd_en); end
      if (sram_rd_addr !== 14'h0) begin n_fail++; $display("FAIL %s_rd_addr: got %h, expected 0", name, sram_rd_addr); end
      if (data_out !== 256'h0)  begin n_fail++; $display("FAIL %s_data: got %h, expected 0", name, data_out); end
      if (busy !== 1'b0)        begin n_fail++; $display("FAIL %s_busy: got %b, expected 0", name, busy); end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      check_idle_outputs("reset");
      rst = 1'b1;
      tick();
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b, expected 0", busy); end
   endtask

   task automatic test_sp();
      sp0_wrr1 = 1'b0;
      push_pkt(4, 14'h100, 3);
      push_pkt(0, 14'h200, 1);
      load(0, 3'd1, 14'h200, 8'd1, 1);
      load(4, 3'd6, 14'h100, 8'd3, 1);
      wait_done("sp", 200);
   endtask

   task automatic test_sp_tie();
      sp0_wrr1 = 1'b0;
      push_pkt(2, 14'h020, 0);
      push_pkt(9, 14'h090, 0);
      push_pkt(12, 14'h0C0, 0);
      load(12, 3'd4, 14'h0C0, 8'd0, 1);
      load(9, 3'd5, 14'h090, 8'd0, 1);
      load(2, 3'd5, 14'h020, 8'd0, 1);
      wait_done("sp_tie", 200);
   endtask

   task automatic test_wrr();
      do_reset();
      sp0_wrr1 = 1'b1;
      push_pkt(1, 14'h010, 0);
      push_pkt(1, 14'h010, 0);
      push_pkt(3, 14'h030, 0);
      push_pkt(1, 14'h010, 0);
      push_pkt(1, 14'h010, 0);
      push_pkt(3, 14'h030, 0);
      load(1, 3'd1, 14'h010, 8'd0, 4);
      load(3, 3'd0, 14'h030, 8'd0, 2);
      wait_done("wrr", 300);
   endtask

   task automatic test_backpressure();
      int c = 0;
      int b0;
      sp0_wrr1 = 1'b0;
      ready = '1;
      push_pkt(5, 14'h2A0, 7);
      load(5, 3'd2, 14'h2A0, 8'd7, 1);
      while (grant[5] !== 1'b1 && c < 50) begin
         tick();
         c++;
      end
      n_tests++;
      if (c >= 50) begin
         n_fail++;
         $display("FAIL bp_grant: got no grant, expected grant[5]");
      end else begin
         tick();                // READ cycle 2
         tick();                // READ cycle 3: sink drops ready
         ready[5] = 1'b0;
         b0 = beats_seen;
         tick();
         n_tests++;
         if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en_c4: got %b, expected 0", sram_rd_en); end
         tick();
         n_tests++;
         if (sram_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en_c5: got %b, expected 0", sram_rd_en); end
         tick();
         n_tests++;
         if (beats_seen - b0 > 1) begin
            n_fail++;
            $display("FAIL bp_overrun: got %0d beats after ready fell, expected at most 1", beats_seen - b0);
         end
         ready[5] = 1'b1;
      end
      wait_done("bp", 200);
   endtask

   task automatic test_wrap();
      sp0_wrr1 = 1'b0;
      push_pkt(7, 14'h3FFE, 3);
      load(7, 3'd0, 14'h3FFE, 8'd3, 1);
      wait_done("wrap", 200);
   endtask

   task automatic test_reset_mid();
      int c = 0;
      int b0 = beats_seen;
      sp0_wrr1 = 1'b1;
      // pointer is 4 from the WRR test, so port 6 wins before the reset
      push_pkt(6, 14'h600, 7);
      load(2, 3'd0, 14'h400, 8'd7, 1);
      load(6, 3'd0, 14'h600, 8'd7, 1);
      while (beats_seen - b0 < 2 && c < 100) begin
         tick();
         c++;
      end
      n_tests++;
      if (c >= 100) begin
         n_fail++;
         $display("FAIL rstmid_start: got %0d beats, expected 2", beats_seen - b0);
      end
      rst = 1'b0;
      sb.delete();
      gq.delete();
      d_cnt[6] = 1;
      drive_req();
      tick();
      check_idle_outputs("rstmid");
      rst = 1'b1;
      tick();
      n_tests++;
      if (vld !== 16'h0) begin n_fail++; $display("FAIL rstmid_inflight: got vld=%h, expected 0", vld); end
      // pointer back at 0: port 2 first
      push_pkt(2, 14'h400, 7);
      push_pkt(6, 14'h600, 7);
      wait_done("rstmid", 300);
   endtask

   initial begin
      rst = 1'b0;
      sp0_wrr1 = 1'b0;
      ready = '1;
      for (int i = 0; i < 16; i++) begin
         d_prio[i] = '0; d_addr[i] = '0; d_len[i] = '0; d_cnt[i] = 0;
      end
      drive_req();
      test_reset();
      test_sp();
      test_sp_tie();
      test_wrr();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
